// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bus bundle shared between a master and the register-file slave.
interface axi4_lite_if #(
    parameter int unsigned ADDR_BIT_WIDTH = 32,
    parameter int unsigned DATA_BIT_WIDTH = 32
);
    logic                          awvalid;
    logic                          awready;
    logic [ADDR_BIT_WIDTH-1:0]     awaddr;
    logic [2:0]                    awprot;

    logic                          wvalid;
    logic                          wready;
    logic [DATA_BIT_WIDTH-1:0]     wdata;
    logic [DATA_BIT_WIDTH/8-1:0]   wstrb;

    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;

    logic                          arvalid;
    logic                          arready;
    logic [ADDR_BIT_WIDTH-1:0]     araddr;
    logic [2:0]                    arprot;

    logic                          rvalid;
    logic                          rready;
    logic [DATA_BIT_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;

    modport mst_port (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slv_port (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file with byte strobes and flat register outputs.
// Define AXI4_LITE_SLV_DECERR_EN to answer out-of-range accesses with DECERR.
module axi4_lite_slv_reg_file #(
    parameter int unsigned ADDR_BIT_WIDTH = 32,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned NUM_REGS       = 8
) (
    input  logic                                i_clk,
    input  logic                                i_arst_n,
    axi4_lite_if.slv_port                       if_s_axi,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  o_regs,
    output logic [NUM_REGS-1:0]                 o_wr_stb
);
    localparam int unsigned StrbWidth = DATA_BIT_WIDTH / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam logic [1:0]  RespOkay  = 2'b00;
`ifdef AXI4_LITE_SLV_DECERR_EN
    localparam logic [1:0]  RespOor   = 2'b11;
`else
    localparam logic [1:0]  RespOor   = 2'b00;
`endif

    logic                       aw_full_q, aw_full_d;
    logic [ADDR_BIT_WIDTH-1:0]  aw_addr_q, aw_addr_d;
    logic                       w_full_q, w_full_d;
    logic [DATA_BIT_WIDTH-1:0]  w_data_q, w_data_d;
    logic [StrbWidth-1:0]       w_strb_q, w_strb_d;

    logic                       awready_q, awready_d;
    logic                       wready_q, wready_d;
    logic                       arready_q, arready_d;

    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       rvalid_q, rvalid_d;
    logic [DATA_BIT_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;

    logic [DATA_BIT_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_BIT_WIDTH-1:0]  regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]        wr_stb_q, wr_stb_d;

    logic                       aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                       commit;
    logic [ADDR_BIT_WIDTH-1:0]  cur_awaddr;
    logic [DATA_BIT_WIDTH-1:0]  cur_wdata;
    logic [StrbWidth-1:0]       cur_wstrb;
    logic [ADDR_BIT_WIDTH-1:0]  wr_word, rd_word;
    logic                       wr_in_range, rd_in_range;
    logic [DATA_BIT_WIDTH-1:0]  rd_data;
    logic                       unused_prot;

    assign unused_prot = ^{if_s_axi.awprot, if_s_axi.arprot};

    assign aw_hs = if_s_axi.awvalid & awready_q;
    assign w_hs  = if_s_axi.wvalid & wready_q;
    assign ar_hs = if_s_axi.arvalid & arready_q;
    assign b_hs  = bvalid_q & if_s_axi.bready;
    assign r_hs  = rvalid_q & if_s_axi.rready;

    // A beat arriving this cycle bypasses its empty buffer so AW+W commit with no extra cycle.
    assign cur_awaddr = aw_full_q ? aw_addr_q : if_s_axi.awaddr;
    assign cur_wdata  = w_full_q ? w_data_q : if_s_axi.wdata;
    assign cur_wstrb  = w_full_q ? w_strb_q : if_s_axi.wstrb;
    assign commit     = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~bvalid_q;

    assign wr_word     = cur_awaddr >> AddrLsb;
    assign wr_in_range = wr_word < ADDR_BIT_WIDTH'(NUM_REGS);
    assign rd_word     = if_s_axi.araddr >> AddrLsb;
    assign rd_in_range = rd_word < ADDR_BIT_WIDTH'(NUM_REGS);

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = if_s_axi.awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = if_s_axi.wdata;
            w_strb_d = if_s_axi.wstrb;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
    end

    always_comb begin
        regs_d   = regs_q;
        wr_stb_d = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (commit && wr_in_range && (wr_word == ADDR_BIT_WIDTH'(k))) begin
                for (int unsigned b = 0; b < StrbWidth; b++) begin
                    if (cur_wstrb[b]) begin
                        regs_d[k][b*8 +: 8] = cur_wdata[b*8 +: 8];
                    end
                end
                wr_stb_d[k] = |cur_wstrb;
            end
        end
    end

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (b_hs) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? RespOkay : RespOor;
        end
    end

    // Reads sample regs_q, so a same-cycle write to the same register is not yet visible.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_word == ADDR_BIT_WIDTH'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (r_hs) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_in_range ? RespOkay : RespOor;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            wr_stb_q  <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wr_stb_q  <= wr_stb_d;
            regs_q    <= regs_d;
        end
    end

    assign if_s_axi.awready = awready_q;
    assign if_s_axi.wready  = wready_q;
    assign if_s_axi.arready = arready_q;
    assign if_s_axi.bvalid  = bvalid_q;
    assign if_s_axi.bresp   = bresp_q;
    assign if_s_axi.rvalid  = rvalid_q;
    assign if_s_axi.rdata   = rdata_q;
    assign if_s_axi.rresp   = rresp_q;
    assign o_wr_stb         = wr_stb_q;

    always_comb begin
        o_regs = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            o_regs[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs_q[k];
        end
    end
endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Scoreboard bench: stimulus pushes expected B/R/strobe results, monitors pop and compare.
module tb_axi4_lite_slv_reg_file;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
`ifdef AXI4_LITE_SLV_DECERR_EN
    localparam logic [1:0] OOR_RESP = 2'b11;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    typedef struct packed {
        logic [7:0]   stb;
        logic [255:0] regs;
    } stb_exp_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();
    logic [NR*DW-1:0] regs;
    logic [NR-1:0]    wr_stb;

    axi4_lite_slv_reg_file #(
        .ADDR_BIT_WIDTH(AW),
        .DATA_BIT_WIDTH(DW),
        .NUM_REGS      (NR)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .if_s_axi (axi.slv_port),
        .o_regs   (regs),
        .o_wr_stb (wr_stb)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model_q [NR];
    logic [1:0]  b_q [$];
    rd_exp_t     r_q [$];
    stb_exp_t    stb_q [$];

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int k = 0; k < NR; k++) f[k*32 +: 32] = model_q[k];
        return f;
    endfunction

    // Reference: word index = addr/4; in range updates strobed bytes, out of range is dropped.
    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_q[idx][b*8 +: 8] = data[b*8 +: 8];
            if (strb != 4'h0) stb_q.push_back('{stb: 8'(1 << idx), regs: model_flat()});
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(OOR_RESP);
        end
    endtask

    task automatic exp_read(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx < NR) r_q.push_back('{data: model_q[idx], resp: 2'b00});
        else          r_q.push_back('{data: 32'h0, resp: OOR_RESP});
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            if (axi.bvalid && axi.bready) begin
                if (b_q.size() == 0) fail_now("bresp unexpected B beat");
                else check("bresp", 256'(axi.bresp), 256'(b_q.pop_front()));
            end
            if (axi.rvalid && axi.rready) begin
                if (r_q.size() == 0) begin
                    fail_now("rdata unexpected R beat");
                end else begin
                    rd_exp_t e;
                    e = r_q.pop_front();
                    check("rdata", 256'(axi.rdata), 256'(e.data));
                    check("rresp", 256'(axi.rresp), 256'(e.resp));
                end
            end
            if (wr_stb != '0) begin
                if (stb_q.size() == 0) begin
                    fail_now("wr_stb unexpected pulse");
                end else begin
                    stb_exp_t s;
                    s = stb_q.pop_front();
                    check("wr_stb", 256'(wr_stb), 256'(s.stb));
                    check("regs at strobe", regs, s.regs);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input logic [31:0] addr);
        int n = 0;
        axi.awaddr  = addr;
        axi.awprot  = 3'($urandom);
        axi.awvalid = 1'b1;
        @(negedge clk);
        while (!axi.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!axi.awready) fail_now("awready timeout");
        @(posedge clk);
        #1 axi.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        @(negedge clk);
        while (!axi.wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!axi.wready) fail_now("wready timeout");
        @(posedge clk);
        #1 axi.wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] addr);
        int n = 0;
        axi.araddr  = addr;
        axi.arprot  = 3'($urandom);
        axi.arvalid = 1'b1;
        @(negedge clk);
        while (!axi.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!axi.arready) fail_now("arready timeout");
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0 || stb_q.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0 || stb_q.size() != 0) begin
            fail_now({name, " response timeout"});
            b_q.delete();
            r_q.delete();
            stb_q.delete();
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        exp_write(addr, data, strb);
        fork
            drive_aw(addr);
            drive_w(data, strb);
        join
    endtask

    initial begin
        logic [31:0]  old_val;
        logic [255:0] snap;
        int n;

        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awprot = '0;
        axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb  = '0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.arprot = '0;
        axi.bready  = 1'b0; axi.rready = 1'b0;
        for (int k = 0; k < NR; k++) model_q[k] = '0;

        // Reset
        step(5);
        check("reset awready", 256'(axi.awready), 256'(0));
        check("reset bvalid", 256'(axi.bvalid), 256'(0));
        @(negedge clk);
        arst_n = 1'b1;
        check("release readies", 256'({axi.awready, axi.wready, axi.arready}), 256'(0));
        check("release valids", 256'({axi.bvalid, axi.rvalid}), 256'(0));
        check("release regs", regs, 256'(0));
        check("release bresp/rresp/rdata", 256'({axi.bresp, axi.rresp, axi.rdata}), 256'(0));
        @(negedge clk);
        check("readies up", 256'({axi.awready, axi.wready, axi.arready}), 256'(3'b111));

        // Full-word write, best-case latency
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        step(1);
        do_write(32'h04, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check("write latency bvalid", 256'(axi.bvalid), 256'(1));
        check("write latency reg1", 256'(regs[63:32]), 256'(32'hDEADBEEF));
        check("write latency wr_stb", 256'(wr_stb), 256'(8'b10));
        @(negedge clk);
        check("wr_stb single pulse", 256'(wr_stb), 256'(0));
        drain("full write");
        step(1);
        exp_read(32'h04);
        drive_ar(32'h04);
        @(negedge clk);
        check("read latency rvalid", 256'(axi.rvalid), 256'(1));
        drain("full read");

        // Partial strobe
        step(1);
        do_write(32'h04, 32'h11223344, 4'b0101);
        drain("partial write");
        check("partial reg1", 256'(regs[63:32]), 256'(32'hDE22BE44));
        step(1);
        exp_read(32'h04);
        drive_ar(32'h04);
        drain("partial read");

        // W three cycles ahead of AW
        step(1);
        exp_write(32'h08, 32'hA5A5A5A5, 4'hF);
        drive_w(32'hA5A5A5A5, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check("w-only no bvalid", 256'(axi.bvalid), 256'(0));
            check("w-only reg2 held", 256'(regs[95:64]), 256'(0));
        end
        step(1);
        drive_aw(32'h08);
        drain("w-first write");

        // Response stall: second write accepted but held until B handshake
        step(1);
        axi.bready = 1'b0;
        do_write(32'h0C, $urandom, 4'hF);
        n = 0;
        while (!axi.bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!axi.bvalid) fail_now("stall bvalid timeout");
        old_val = regs[159:128];
        step(1);
        do_write(32'h10, $urandom, 4'hF);
        repeat (4) begin
            @(negedge clk);
            check("stall bvalid held", 256'(axi.bvalid), 256'(1));
            check("stall awready low", 256'(axi.awready), 256'(0));
            check("stall reg4 held", 256'(regs[159:128]), 256'(old_val));
        end
        step(1);
        axi.bready = 1'b1;
        drain("stalled writes");

        // Read back-pressure
        step(1);
        axi.rready = 1'b0;
        exp_read(32'h08);
        drive_ar(32'h08);
        repeat (3) begin
            @(negedge clk);
            check("rstall rvalid", 256'(axi.rvalid), 256'(1));
            check("rstall rdata", 256'(axi.rdata), 256'(32'hA5A5A5A5));
            check("rstall arready", 256'(axi.arready), 256'(0));
        end
        step(1);
        axi.rready = 1'b1;
        drain("stalled read");
        @(negedge clk);
        check("arready after R", 256'(axi.arready), 256'(1));

        // Out of range
        step(1);
        snap = model_flat();
        do_write(32'h40, $urandom, 4'hF);
        drain("oor write");
        check("oor regs unchanged", regs, snap);
        step(1);
        exp_read(32'h40);
        drive_ar(32'h40);
        drain("oor read");

        // Randomized mix, including out-of-range and unaligned addresses
        for (int i = 0; i < 60; i++) begin
            logic [31:0] addr;
            logic [31:0] data;
            logic [3:0]  strb;
            int          mode;
            step(1);
            addr = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 3);
            if (mode == 3) begin
                exp_read(addr);
                drive_ar(addr);
            end else begin
                exp_write(addr, data, strb);
                if (mode == 0) begin
                    fork
                        drive_aw(addr);
                        drive_w(data, strb);
                    join
                end else if (mode == 1) begin
                    drive_aw(addr);
                    step($urandom_range(0, 2));
                    drive_w(data, strb);
                end else begin
                    drive_w(data, strb);
                    step($urandom_range(0, 2));
                    drive_aw(addr);
                end
            end
            drain("random");
        end

        @(negedge clk);
        check("final regs", regs, model_flat());
        check("final queues empty", 256'(b_q.size() + r_q.size() + stb_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi4_lite_slv_reg_file.md
Name: axi4_lite_slv_reg_file

Overview:
- AXI4-Lite slave exposing NUM_REGS read/write registers of DATA_BIT_WIDTH bits each, with byte-strobe writes.
- Connects to the bus via the slave modport of the AXI4-Lite interface.
- Register contents and per-register write strobes are driven out flat to fabric logic.
- Sits between an interconnect or CPU master and control/status logic.

Parameters:
- ADDR_BIT_WIDTH, 32, AXI address width; must match the interface instance.
- DATA_BIT_WIDTH, 32, AXI data width; 32 or 64 only; must match the interface instance.
- NUM_REGS, 8, number of registers; ≥1.

Ports:
- i_clk  input  1  clock; same clock as the interface.
- i_arst_n  input  1  asynchronous active-low reset.
- if_s_axi  interface  axi4_lite_if.slv_port  AXI4-Lite slave side.
- o_regs  output  NUM_REGS*DATA_BIT_WIDTH  register contents; reg k occupies bits [k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH].
- o_wr_stb  output  NUM_REGS  1-cycle pulse when reg k is written (any strobe bit set).

Behaviour:
- Clock and reset: one clock (i_clk); reset i_arst_n is asynchronous, active-low; all flops clear immediately on assertion.
- Reset values:
  - awready, wready, arready, bvalid, rvalid = 0.
  - bresp, rresp = 2'b00; rdata = 0.
  - all registers = 0; o_wr_stb = 0.
- Readies: awready, wready and arready go high on the first clock edge after reset release.
- Address decode: byte address; word index = addr >> log2(DATA_BIT_WIDTH/8); low bits ignored. Index ≥ NUM_REGS is out of range. awprot and arprot are ignored.
- Write address and data channels are independent and each has a 1-entry holding buffer:
  - awready = 1 while the AW buffer is empty; AW handshake (awvalid & awready) loads awaddr and drops awready.
  - wready behaves the same for W, capturing wdata and wstrb.
  - AW and W may arrive in either order or the same cycle.
- Write commit: on the cycle both buffers are full and bvalid = 0, the write is performed:
  - for each byte i with wstrb[i]=1, reg[idx] byte i takes wdata byte i;
  - o_wr_stb[idx] pulses that cycle if any strobe bit is set and the address is in range;
  - both buffers empty; bvalid rises on the next edge with bresp set.
- Write response:
  - bresp = OKAY (2'b00) in range; out of range: no register change, bresp per Optional Feature.
  - bvalid holds until bready; buffers may refill while bvalid = 1, but the next commit waits until bvalid drops.
- Best-case write latency: AW+W in cycle 0 → register updated at edge 1, bvalid high in cycle 1.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rdata = reg[idx] (or 0 if out of range), rresp set, rvalid = 1 at the next edge (1-cycle latency).
  - rvalid and rdata are held stable until rready; arready returns high the cycle after the R handshake (one read outstanding).
- Read/write ordering: a read and a write to the same register in the same cycle returns the pre-write value.
- Protocol: valid/ready never combinationally depends on the master's ready; the slave never drops bvalid or rvalid without a handshake.
- Reset mid-transaction: pending buffers and responses are discarded; registers clear.

Optional Feature:
- Macro AXI4_LITE_SLV_DECERR_EN.
- Defined: out-of-range read or write returns 2'b11 (DECERR); read data = 0.
- Undefined: out-of-range accesses return 2'b00 (OKAY); writes are silently dropped and reads return 0.
- In-range behaviour is identical either way.

Test Plan:
- Reset: hold i_arst_n=0 for 5 cycles then release → all valids 0, o_regs=0; awready=wready=arready=1 one cycle later.
- Full-word write: AW addr 0x04 and W data 0xDEADBEEF strb 0xF in the same cycle, bready=1 → reg1=0xDEADBEEF, o_wr_stb=0b10 for 1 cycle, bvalid 1 cycle later with bresp=0; read 0x04 → rdata=0xDEADBEEF, rresp=0, 1-cycle latency.
- Partial strobe: reg1=0xDEADBEEF, write 0x11223344 strb 0b0101 → read-back 0xDE22BE44.
- Decoupled channels with response stall:
  - W 3 cycles before AW (addr 0x08, data 0xA5A5A5A5) → commit only after AW.
  - bready held low 4 cycles → bvalid stays 1, second AW/W accepted but not committed until the B handshake.
- Read back-pressure: rready low 3 cycles after a read of reg2 → rvalid/rdata stable, arready=0 until the handshake.
- Out of range: NUM_REGS=8, write then read addr 0x40 → registers unchanged, rdata=0; resp=2'b11 with AXI4_LITE_SLV_DECERR_EN, 2'b00 without.
